// File: rtl/atmega_spi_mx.sv
// atmega_spi_mx: FIFO-buffered ATmega-compatible SPI master with SPCR/SPSR/SPDR on the 8-bit IO bus.
// Define ATMEGA_SPI_MX_SS_EN to add the ss_n_o slave-select output and its hold timer.
module atmega_spi_mx #(
   parameter PLATFORM = "XILINX",
   parameter int BUS_ADDR_DATA_LEN = 8,
   parameter logic [BUS_ADDR_DATA_LEN-1:0] SPCR_ADDR = 'h20,
   parameter logic [BUS_ADDR_DATA_LEN-1:0] SPSR_ADDR = 'h21,
   parameter logic [BUS_ADDR_DATA_LEN-1:0] SPDR_ADDR = 'h22,
   parameter int FIFO_DEPTH = 4,
   parameter DINAMIC_BAUDRATE = "TRUE",
   parameter int BAUDRATE_DIVIDER = 1,
   parameter USE_TX = "TRUE",
   parameter USE_RX = "TRUE"
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic [BUS_ADDR_DATA_LEN-1:0] addr_i,
   input  logic                         wr_i,
   input  logic                         rd_i,
   input  logic [7:0]                   bus_i,
   output logic [7:0]                   bus_o,
   output logic                         int_o,
   input  logic                         int_ack_i,
   output logic                         io_connect_o,
   output logic                         io_conn_slave_o,
   output logic                         scl_o,
   output logic                         mosi_o,
`ifdef ATMEGA_SPI_MX_SS_EN
   output logic                         ss_n_o,
`endif
   input  logic                         miso_i
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
   localparam bit TX_EN = (USE_TX == "TRUE");
   localparam bit RX_EN = (USE_RX == "TRUE");

   if (PLATFORM == "") begin : g_platform_untagged
   end

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
   state_t state, state_nx;

   logic [7:0]  spcr;
   logic        spi2x, spif, wcol, rovr;
   logic        spie, spe, dord, cpol, cpha;
   logic [7:0]  tx_mem [FIFO_DEPTH];
   logic [7:0]  rx_mem [FIFO_DEPTH];
   logic [AW:0] tx_wp, tx_rp, rx_wp, rx_rp, rx_cnt;
   logic        tx_empty, tx_full, rx_empty, rx_full;
   logic [7:0]  tx_head, rx_head, tx_sr, rx_sr;
   logic [15:0] h_sel, h_lat, div_cnt;
   logic [3:0]  edge_cnt;
   logic        scl_q, edge_tick, sample_edge, shift_edge;
   logic        sel_spcr, sel_spsr, sel_spdr, abort, done_ok;
   logic        tx_push_req, tx_push, tx_pop, rx_push, rx_pop, rx_to_empty;

   assign spie = spcr[7];
   assign spe  = spcr[6];
   assign dord = spcr[5];
   assign cpol = spcr[3];
   assign cpha = spcr[2];

   assign sel_spcr = (addr_i == SPCR_ADDR);
   assign sel_spsr = (addr_i == SPSR_ADDR);
   assign sel_spdr = (addr_i == SPDR_ADDR);
   // Clearing SPE while it is set aborts the byte in flight and flushes both FIFOs.
   assign abort    = wr_i & sel_spcr & spe & ~bus_i[6];
   assign done_ok  = (state == DONE) & ~abort;

   assign tx_empty = (tx_wp == tx_rp);
   assign tx_full  = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
   assign rx_empty = (rx_wp == rx_rp);
   assign rx_full  = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
   assign rx_cnt   = rx_wp - rx_rp;
   assign tx_head  = tx_mem[tx_rp[AW-1:0]];
   assign rx_head  = rx_mem[rx_rp[AW-1:0]];

   assign tx_pop      = (state == LOAD);
   assign tx_push_req = wr_i & sel_spdr;
   assign tx_push     = tx_push_req & (~tx_full | tx_pop);
   assign rx_push     = RX_EN & done_ok & ~rx_full;
   assign rx_pop      = rd_i & sel_spdr & ~rx_empty;
   assign rx_to_empty = rx_pop & ~rx_push & (rx_cnt == PTR_ONE);

   assign edge_tick   = (state == SHIFT) && (div_cnt == h_lat - 16'd1);
   // Edge number is edge_cnt+1: odd edges are leading, even edges trailing.
   assign sample_edge = cpha ? edge_cnt[0] : ~edge_cnt[0];
   assign shift_edge  = ~sample_edge && (edge_cnt != 4'd0) && (edge_cnt != 4'd15);

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      h_sel = 16'(BAUDRATE_DIVIDER);
      if (DINAMIC_BAUDRATE == "TRUE") begin
         case ({spi2x, spcr[1:0]})
            3'b000:  h_sel = 16'd2;
            3'b001:  h_sel = 16'd8;
            3'b010:  h_sel = 16'd32;
            3'b011:  h_sel = 16'd64;
            3'b100:  h_sel = 16'd1;
            3'b101:  h_sel = 16'd4;
            3'b110:  h_sel = 16'd16;
            default: h_sel = 16'd32;
         endcase
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:  if (spe && !tx_empty) state_nx = LOAD;
         LOAD:  state_nx = SHIFT;
         SHIFT: if (edge_tick && edge_cnt == 4'd15) state_nx = DONE;
         DONE:  state_nx = tx_empty ? IDLE : LOAD;
      endcase
      if (abort) state_nx = IDLE;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= IDLE;
         h_lat    <= 16'd1;
         div_cnt  <= '0;
         edge_cnt <= '0;
         scl_q    <= 1'b1;
         tx_sr    <= '0;
         rx_sr    <= '0;
      end else begin
         state <= state_nx;
         case (state)
            LOAD: begin
               h_lat    <= h_sel;
               div_cnt  <= '0;
               edge_cnt <= '0;
               scl_q    <= cpol;
               tx_sr    <= tx_head;
            end
            SHIFT: begin
               if (edge_tick) begin
                  div_cnt  <= '0;
                  edge_cnt <= edge_cnt + 4'd1;
                  scl_q    <= ~scl_q;
                  if (sample_edge) rx_sr <= dord ? {miso_i, rx_sr[7:1]} : {rx_sr[6:0], miso_i};
                  if (shift_edge)  tx_sr <= dord ? {1'b0, tx_sr[7:1]} : {tx_sr[6:0], 1'b0};
               end else begin
                  div_cnt <= div_cnt + 16'd1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || abort) begin
         tx_wp <= '0;
         tx_rp <= '0;
         rx_wp <= '0;
         rx_rp <= '0;
      end else begin
         if (tx_push) tx_wp <= tx_wp + PTR_ONE;
         if (tx_pop)  tx_rp <= tx_rp + PTR_ONE;
         if (rx_push) rx_wp <= rx_wp + PTR_ONE;
         if (rx_pop)  rx_rp <= rx_rp + PTR_ONE;
      end
   end

   // NOTE: FIFO storage is deliberately not reset; the pointers alone define valid entries.
   always_ff @(posedge clk_i) begin
      if (tx_push) tx_mem[tx_wp[AW-1:0]] <= bus_i;
      if (rx_push) rx_mem[rx_wp[AW-1:0]] <= rx_sr;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         spcr  <= '0;
         spi2x <= 1'b0;
         spif  <= 1'b0;
         wcol  <= 1'b0;
         rovr  <= 1'b0;
      end else begin
         if (wr_i && sel_spcr) begin
            if (state == IDLE) spcr <= bus_i;
            else               spcr[7:6] <= bus_i[7:6];
         end
         if (wr_i && sel_spsr) spi2x <= bus_i[0];
         // Set wins over clear for all three sticky flags.
         if (done_ok)                         spif <= 1'b1;
         else if (int_ack_i || rx_to_empty)   spif <= 1'b0;
         if (tx_push_req && !tx_push)         wcol <= 1'b1;
         else if (rd_i && sel_spsr)           wcol <= 1'b0;
         if (RX_EN && done_ok && rx_full)     rovr <= 1'b1;
         else if (rd_i && sel_spsr)           rovr <= 1'b0;
      end
   end

   always_comb begin
      bus_o = 8'h00;
      if (rd_i) begin
         if (sel_spcr)      bus_o = spcr;
         else if (sel_spsr) bus_o = {spif, wcol, tx_full, rx_empty, rovr, 2'b00, spi2x};
         else if (sel_spdr) bus_o = rx_empty ? 8'hFF : rx_head;
      end
   end

   always_comb begin
      mosi_o = 1'b1;
      if (spe && TX_EN) begin
         if (state == LOAD)      mosi_o = dord ? tx_head[0] : tx_head[7];
         else if (state != IDLE) mosi_o = dord ? tx_sr[0] : tx_sr[7];
      end
   end

   assign scl_o           = ~spe ? 1'b1 : ((state == SHIFT) ? scl_q : cpol);
   assign int_o           = spie & spif;
   assign io_connect_o    = spe;
   assign io_conn_slave_o = ~spcr[4];

`ifdef ATMEGA_SPI_MX_SS_EN
   logic        ss_q;
   logic [15:0] ss_hold;

   // Select stays low for one half-period after the last byte of a burst completes.
   always_ff @(posedge clk_i) begin
      if (rst_i || abort) begin
         ss_q    <= 1'b1;
         ss_hold <= '0;
      end else if (state == LOAD) begin
         ss_q    <= 1'b0;
         ss_hold <= '0;
      end else if (state == DONE && tx_empty) begin
         ss_hold <= h_lat;
      end else if (state == IDLE && ss_hold != 16'd0) begin
         ss_hold <= ss_hold - 16'd1;
         if (ss_hold == 16'd1) ss_q <= 1'b1;
      end
   end

   assign ss_n_o = ss_q;
`endif

endmodule

// File: tb/tb_atmega_spi_mx.sv
// tb_atmega_spi_mx: directed bench for atmega_spi_mx with an SPI slave model that drives miso and records mosi.
module tb_atmega_spi_mx;

   localparam logic [7:0] SPCR = 8'h20, SPSR = 8'h21, SPDR = 8'h22;

   logic       clk = 1'b0, rst, wr, rd, int_ack, miso;
   logic [7:0] addr, wdata, rdata, d;
   logic       int_o, io_connect, io_slave, scl, mosi;
   int         n_checks = 0, n_fail = 0;

   atmega_spi_mx dut (
      .clk_i(clk), .rst_i(rst), .addr_i(addr), .wr_i(wr), .rd_i(rd),
      .bus_i(wdata), .bus_o(rdata), .int_o(int_o), .int_ack_i(int_ack),
      .io_connect_o(io_connect), .io_conn_slave_o(io_slave),
      .scl_o(scl), .mosi_o(mosi), .miso_i(miso)
   );

   always #5 clk = ~clk;

   // Slave model state
   bit         mon_cpol, mon_cpha, mon_dord, first_bit, prev_scl;
   logic [2:0] samp_cnt;
   logic [7:0] slave_cur, mosi_acc;
   logic [7:0] slave_q[$];
   logic [7:0] mosi_q[$];
   int         cyc = 0, last_edge = 0, max_gap = 0, n_edges = 0;

   assign miso = mon_dord ? slave_cur[samp_cnt] : slave_cur[3'd7 - samp_cnt];

   always @(negedge clk) begin
      cyc++;
      if (scl !== prev_scl) begin
         if (n_edges > 0 && (cyc - last_edge) > max_gap) max_gap = cyc - last_edge;
         last_edge = cyc;
         n_edges++;
         if ((scl != mon_cpol) != mon_cpha) begin
            if (samp_cnt == 3'd0) first_bit = mosi;
            mosi_acc = mon_dord ? {mosi, mosi_acc[7:1]} : {mosi_acc[6:0], mosi};
            if (samp_cnt == 3'd7) begin
               mosi_q.push_back(mosi_acc);
               slave_cur = (slave_q.size() > 0) ? slave_q.pop_front() : 8'h00;
            end
            samp_cnt++;
         end
      end
      prev_scl = scl;
   end

   task automatic mon_reset();
      samp_cnt  = 3'd0;
      mosi_acc  = 8'h00;
      n_edges   = 0;
      max_gap   = 0;
      first_bit = 1'b0;
      mosi_q.delete();
      slave_cur = (slave_q.size() > 0) ? slave_q.pop_front() : 8'h00;
      prev_scl  = scl;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic bus_write(input logic [7:0] a, input logic [7:0] v);
      addr = a; wdata = v; wr = 1'b1;
      @(negedge clk);
      wr = 1'b0;
   endtask

   task automatic bus_read(input logic [7:0] a, output logic [7:0] v);
      addr = a; rd = 1'b1;
      #1 v = rdata;
      @(negedge clk);
      rd = 1'b0;
   endtask

   task automatic wait_bytes(input string tag, input int n, input int budget);
      int k = 0;
      while (mosi_q.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      check(tag, mosi_q.size(), n);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; wr = 1'b0; rd = 1'b0; int_ack = 1'b0; addr = 8'h00; wdata = 8'h00;
      mon_cpol = 1'b0; mon_cpha = 1'b0; mon_dord = 1'b0;
      mon_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Reset state
      check("rst_scl", scl, 1'b1);
      check("rst_mosi", mosi, 1'b1);
      check("rst_int", int_o, 1'b0);
      check("rst_io_connect", io_connect, 1'b0);
      check("rst_io_slave", io_slave, 1'b1);
      check("rst_bus_idle", rdata, 8'h00);
      bus_read(SPSR, d); check("rst_spsr", d, 8'h10);
      bus_read(SPCR, d); check("rst_spcr", d, 8'h00);
      bus_read(SPDR, d); check("rst_spdr_empty", d, 8'hFF);
      bus_write(SPSR, 8'hFF);
      bus_read(SPSR, d); check("spsr_spi2x_only", d, 8'h11);
      bus_write(SPSR, 8'h00);

      // Mode 0, H=2, single byte
      bus_write(SPCR, 8'h50);
      check("m0_io_connect", io_connect, 1'b1);
      check("m0_io_slave", io_slave, 1'b0);
      check("m0_idle_scl", scl, 1'b0);
      check("m0_idle_mosi", mosi, 1'b1);
      slave_q = '{8'h3C}; mon_cpol = 1'b0; mon_cpha = 1'b0; mon_dord = 1'b0;
      @(negedge clk); mon_reset();
      bus_write(SPDR, 8'hA5);
      repeat (20) @(negedge clk);
      bus_read(SPSR, d); check("m0_busy_spsr", d, 8'h10);
      wait_bytes("m0_wait", 1, 100);
      repeat (4) @(negedge clk);
      check("m0_mosi_byte", mosi_q[0], 8'hA5);
      check("m0_edges", n_edges, 16);
      bus_read(SPSR, d); check("m0_spif", d, 8'h80);
      bus_read(SPDR, d); check("m0_rx", d, 8'h3C);
      bus_read(SPSR, d); check("m0_spif_clr_empty", d, 8'h10);
      check("m0_end_scl", scl, 1'b0);
      check("m0_end_mosi", mosi, 1'b1);

      // Mode 3 burst of four bytes
      bus_write(SPCR, 8'h5C);
      slave_q = '{8'h11, 8'h22, 8'h33, 8'h44}; mon_cpol = 1'b1; mon_cpha = 1'b1;
      @(negedge clk); mon_reset();
      check("m3_idle_scl", scl, 1'b1);
      bus_write(SPDR, 8'h81); bus_write(SPDR, 8'h42);
      bus_write(SPDR, 8'h24); bus_write(SPDR, 8'h18);
      wait_bytes("m3_wait", 4, 400);
      repeat (6) @(negedge clk);
      check("m3_mosi0", mosi_q[0], 8'h81);
      check("m3_mosi1", mosi_q[1], 8'h42);
      check("m3_mosi2", mosi_q[2], 8'h24);
      check("m3_mosi3", mosi_q[3], 8'h18);
      check("m3_edges", n_edges, 64);
      check("m3_max_gap", max_gap, 4);
      bus_read(SPSR, d); check("m3_spsr", d, 8'h80);
      bus_read(SPDR, d); check("m3_rx0", d, 8'h11);
      bus_read(SPDR, d); check("m3_rx1", d, 8'h22);
      bus_read(SPDR, d); check("m3_rx2", d, 8'h33);
      bus_read(SPDR, d); check("m3_rx3", d, 8'h44);
      bus_read(SPSR, d); check("m3_spsr_end", d, 8'h10);

      // H=64: TX overflow (WCOL) then RX overrun (ROVR)
      bus_write(SPCR, 8'h53);
      slave_q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5}; mon_cpol = 1'b0; mon_cpha = 1'b0;
      @(negedge clk); mon_reset();
      for (int i = 1; i <= 6; i++) bus_write(SPDR, 8'(i));
      bus_read(SPSR, d); check("ov_wcol_txfull", d, 8'h70);
      bus_read(SPSR, d); check("ov_wcol_clr", d, 8'h30);
      wait_bytes("ov_wait2", 2, 2500);
      bus_read(SPSR, d); check("ov_txfull_clr", d, 8'h80);
      wait_bytes("ov_wait5", 5, 5000);
      repeat (80) @(negedge clk);
      check("ov_count", mosi_q.size(), 5);
      check("ov_mosi_first", mosi_q[0], 8'h01);
      check("ov_mosi_last", mosi_q[4], 8'h05);
      bus_read(SPSR, d); check("ov_rovr", d, 8'h88);
      bus_read(SPDR, d); check("ov_rx0", d, 8'hC1);
      bus_read(SPDR, d); check("ov_rx1", d, 8'hC2);
      bus_read(SPDR, d); check("ov_rx2", d, 8'hC3);
      bus_read(SPDR, d); check("ov_rx3", d, 8'hC4);
      bus_read(SPSR, d); check("ov_spsr_clr", d, 8'h10);
      bus_read(SPDR, d); check("ov_rx_empty", d, 8'hFF);

      // Abort mid-byte by clearing SPE
      bus_write(SPCR, 8'h50);
      bus_write(SPDR, 8'h77);
      bus_write(SPDR, 8'h88);
      repeat (8) @(negedge clk);
      bus_write(SPCR, 8'h1C);
      check("ab_scl", scl, 1'b1);
      check("ab_mosi", mosi, 1'b1);
      bus_read(SPSR, d); check("ab_fifos_empty", d, 8'h10);
      bus_read(SPCR, d); check("ab_spcr_masked", d, 8'h10);
      repeat (60) @(negedge clk);
      bus_read(SPSR, d); check("ab_no_spif", d, 8'h10);

      // LSB first with interrupt
      bus_write(SPCR, 8'hF0);
      slave_q = '{8'h5A}; mon_cpol = 1'b0; mon_cpha = 1'b0; mon_dord = 1'b1;
      @(negedge clk); mon_reset();
      check("lsb_int_idle", int_o, 1'b0);
      bus_write(SPDR, 8'h01);
      wait_bytes("lsb_wait", 1, 100);
      check("lsb_first_bit", first_bit, 1'b1);
      check("lsb_mosi_byte", mosi_q[0], 8'h01);
      repeat (6) @(negedge clk);
      check("lsb_int_set", int_o, 1'b1);
      int_ack = 1'b1;
      @(negedge clk);
      int_ack = 1'b0;
      check("lsb_int_ack", int_o, 1'b0);
      bus_read(SPDR, d); check("lsb_rx", d, 8'h5A);

      // Reset in the middle of a transfer
      bus_write(SPDR, 8'hFF);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mr_scl", scl, 1'b1);
      check("mr_mosi", mosi, 1'b1);
      check("mr_io_connect", io_connect, 1'b0);
      check("mr_io_slave", io_slave, 1'b1);
      bus_read(SPCR, d); check("mr_spcr", d, 8'h00);
      bus_read(SPSR, d); check("mr_spsr", d, 8'h10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
